// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: pipeline hazard controller driving per-latch enable/flush and
// the PC enable. Registered state adds a multi-bubble load-use stall counter,
// data-memory wait freezing and a sticky halt state.
//
// Optional feature: define PIPELINE_CTRL_PERF_EN to build the saturating
// stall-cycle and mispredict-flush performance counters. Without it the
// perf outputs are tied to zero and no counter flops exist.
//
// Handshake-free block: every output except halted and the perf counters is a
// pure combinational decode of the current state and this cycle's inputs.
module pipeline_ctrl #(
    parameter int NSTAGES     = 4,
    parameter int FLUSH_DEPTH = 3,
    parameter int REGW        = 5,
    parameter int LU_BUBBLES  = 1,
    parameter int CNT_W       = 32
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [REGW-1:0]    id_rs,
    input  logic [REGW-1:0]    id_rt,
    input  logic [REGW-1:0]    ex_rd,
    input  logic               ex_regwen,
    input  logic               ex_dren,
    input  logic               mispredict,
    input  logic               ihit,
    input  logic               dmem_req,
    input  logic               dhit,
    input  logic               halt,
    output logic [NSTAGES-1:0] stage_en,
    output logic [NSTAGES-1:0] stage_flush,
    output logic               pcen,
    output logic               halted,
    output logic [CNT_W-1:0]   perf_stall,
    output logic [CNT_W-1:0]   perf_flush
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        HALTED   = 2'd2
    } state_e;

    // Latch masks: all latches, the mispredict flush window, IF/ID, ID/EX.
    localparam logic [NSTAGES-1:0] ALL_ONES    = '1;
    localparam logic [NSTAGES-1:0] MISP_MASK   = ALL_ONES >> (NSTAGES - FLUSH_DEPTH);
    localparam logic [NSTAGES-1:0] IFID_MASK   = NSTAGES'(1);
    localparam logic [NSTAGES-1:0] IDEX_MASK   = NSTAGES'(2);
    // Bubbles still owed after the first one inserted from RUN.
    localparam logic [2:0]         LU_RELOAD   = 3'(LU_BUBBLES - 1);

    state_e     state_q, state_d;
    logic [2:0] lu_cnt_q, lu_cnt_d;
    logic       lu_hazard;

    // Load in EX feeding a source register of the instruction in ID; r0 never stalls.
    assign lu_hazard = ex_dren && ex_regwen && (ex_rd != '0) &&
                       ((ex_rd == id_rs) || (ex_rd == id_rt));

    // State and bubble-counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= RUN;
            lu_cnt_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
        end
    end

    // Priority decode: halt, data wait, mispredict, load-use, instruction wait.
    always_comb begin
        state_d     = state_q;
        lu_cnt_d    = lu_cnt_q;
        stage_en    = ALL_ONES;
        stage_flush = '0;
        pcen        = 1'b1;

        if ((state_q == HALTED) || halt) begin
            // Drain: keep clocking latches but fill them with bubbles forever.
            pcen        = 1'b0;
            stage_flush = ALL_ONES;
            state_d     = HALTED;
        end else if (dmem_req && !dhit) begin
            // Whole pipe freezes; state and bubble count hold.
            stage_en = '0;
            pcen     = 1'b0;
        end else if (mispredict) begin
            // Redirect fetch and squash the wrong-path latches; abort any stall.
            stage_flush = MISP_MASK;
            state_d     = RUN;
            lu_cnt_d    = 3'd0;
        end else if ((state_q == LU_STALL) || lu_hazard) begin
            // Hold IF/ID and the PC, inject a bubble into ID/EX.
            stage_en    = ALL_ONES & ~IFID_MASK;
            stage_flush = IDEX_MASK;
            pcen        = 1'b0;
            if (state_q == LU_STALL) begin
                lu_cnt_d = lu_cnt_q - 3'd1;
                if (lu_cnt_q == 3'd1) begin
                    state_d = RUN;
                end
            end else if (LU_BUBBLES > 1) begin
                state_d  = LU_STALL;
                lu_cnt_d = LU_RELOAD;
            end
        end else if (!ihit) begin
            // Fetch not back yet: hold PC, bubble IF/ID, let the rest advance.
            stage_flush = IFID_MASK;
            pcen        = 1'b0;
        end
    end

    assign halted = (state_q == HALTED);

`ifdef PIPELINE_CTRL_PERF_EN
    logic             misp_active;
    logic [CNT_W-1:0] perf_stall_q;
    logic [CNT_W-1:0] perf_flush_q;

    assign misp_active = mispredict && (state_q != HALTED) && !halt &&
                         !(dmem_req && !dhit);

    // Saturating counters of stalled (non-halted) cycles and mispredict flushes.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (!pcen && (state_q != HALTED) && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + CNT_W'(1);
            end
            if (misp_active && (perf_flush_q != '1)) begin
                perf_flush_q <= perf_flush_q + CNT_W'(1);
            end
        end
    end

    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
`else
    assign perf_stall = '0;
    assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (LU_BUBBLES=1 and LU_BUBBLES=3 with a
// 3-bit counter width) share one stimulus stream; a vector table plus a few
// hand-written reset/halt sequences, checked through an expected-value queue.
module tb_pipeline_ctrl;

    logic       CLK;
    logic       nRST;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       ex_regwen, ex_dren, mispredict, ihit, dmem_req, dhit, halt;

    logic [3:0]  en1, fl1, en3, fl3;
    logic        pc1, pc3, h1, h3;
    logic [31:0] ps1, pf1;
    logic [2:0]  ps3, pf3;

    pipeline_ctrl #(.NSTAGES(4), .FLUSH_DEPTH(3), .REGW(5), .LU_BUBBLES(1), .CNT_W(32)) dut1 (
        .CLK(CLK), .nRST(nRST), .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd),
        .ex_regwen(ex_regwen), .ex_dren(ex_dren), .mispredict(mispredict), .ihit(ihit),
        .dmem_req(dmem_req), .dhit(dhit), .halt(halt),
        .stage_en(en1), .stage_flush(fl1), .pcen(pc1), .halted(h1),
        .perf_stall(ps1), .perf_flush(pf1)
    );

    pipeline_ctrl #(.NSTAGES(4), .FLUSH_DEPTH(3), .REGW(5), .LU_BUBBLES(3), .CNT_W(3)) dut3 (
        .CLK(CLK), .nRST(nRST), .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd),
        .ex_regwen(ex_regwen), .ex_dren(ex_dren), .mispredict(mispredict), .ihit(ihit),
        .dmem_req(dmem_req), .dhit(dhit), .halt(halt),
        .stage_en(en3), .stage_flush(fl3), .pcen(pc3), .halted(h3),
        .perf_stall(ps3), .perf_flush(pf3)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected output word: {stage_en[3:0], stage_flush[3:0], pcen, halted}
    localparam logic [9:0] I  = 10'b1111_0000_10; // idle RUN
    localparam logic [9:0] B  = 10'b1110_0010_00; // load-use bubble
    localparam logic [9:0] MP = 10'b1111_0111_10; // mispredict flush
    localparam logic [9:0] IW = 10'b1111_0001_00; // instruction wait
    localparam logic [9:0] DW = 10'b0000_0000_00; // data wait freeze
    localparam logic [9:0] H0 = 10'b1111_1111_00; // halt decoded, not yet registered
    localparam logic [9:0] H1 = 10'b1111_1111_01; // halted

    typedef struct {
        logic [4:0] ex_rd, id_rs, id_rt;
        logic       dren, regwen, misp, ihit, dreq, dhit, halt;
        logic [9:0] e1, e3;
    } vec_t;

    localparam int NV = 26;
    vec_t tbl [NV];

    int checks = 0;
    int errors = 0;
    logic [19:0] exp_q [$];

`ifdef PIPELINE_CTRL_PERF_EN
    int unsigned m_ps1 = 0, m_pf1 = 0, m_ps3 = 0, m_pf3 = 0;
`endif

    function automatic vec_t mk(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                                input logic dr, input logic rw, input logic mp, input logic ih,
                                input logic dq, input logic dh, input logic hl,
                                input logic [9:0] x1, input logic [9:0] x3);
        vec_t v;
        v.ex_rd = rd; v.id_rs = rs; v.id_rt = rt;
        v.dren = dr; v.regwen = rw; v.misp = mp; v.ihit = ih;
        v.dreq = dq; v.dhit = dh; v.halt = hl;
        v.e1 = x1; v.e3 = x3;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Driver: apply one vector and record what both instances must show.
    task automatic apply(input vec_t v);
        ex_rd = v.ex_rd; id_rs = v.id_rs; id_rt = v.id_rt;
        ex_dren = v.dren; ex_regwen = v.regwen; mispredict = v.misp;
        ihit = v.ihit; dmem_req = v.dreq; dhit = v.dhit; halt = v.halt;
        exp_q.push_back({v.e1, v.e3});
    endtask

    // Scoreboard: pop the oldest expectation and compare both instances.
    task automatic compare(input string nm);
        logic [19:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got none expected one entry", nm);
        end else begin
            e = exp_q.pop_front();
            chk({nm, "_lu1"}, 32'({en1, fl1, pc1, h1}), 32'(e[19:10]));
            chk({nm, "_lu3"}, 32'({en3, fl3, pc3, h3}), 32'(e[9:0]));
        end
    endtask

    task automatic chk_perf_zero(input string nm);
        chk({nm, "_ps1"}, ps1, 32'd0);
        chk({nm, "_pf1"}, pf1, 32'd0);
        chk({nm, "_ps3"}, 32'(ps3), 32'd0);
        chk({nm, "_pf3"}, 32'(pf3), 32'd0);
    endtask

`ifdef PIPELINE_CTRL_PERF_EN
    // Counter model: advance by what this cycle should add (counted on next edge).
    task automatic perf_step(input vec_t v);
        logic dw;
        dw = v.dreq && !v.dhit;
        if (!v.e1[1] && !v.e1[0]) m_ps1 = m_ps1 + 1;
        if (!v.e3[1] && !v.e3[0] && m_ps3 < 7) m_ps3 = m_ps3 + 1;
        if (v.misp && !v.halt && !v.e1[0] && !dw) m_pf1 = m_pf1 + 1;
        if (v.misp && !v.halt && !v.e3[0] && !dw && m_pf3 < 7) m_pf3 = m_pf3 + 1;
    endtask
`endif

    initial begin
        // Vector table: ex_rd, id_rs, id_rt, dren, regwen, misp, ihit, dreq, dhit, halt, exp LU1, exp LU3
        tbl[0]  = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, I,  I);
        tbl[1]  = mk(5'd5, 5'd0, 5'd5, 1, 1, 0, 1, 0, 0, 0, B,  B);
        tbl[2]  = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, I,  B);
        tbl[3]  = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, I,  B);
        tbl[4]  = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, I,  I);
        tbl[5]  = mk(5'd8, 5'd8, 5'd0, 1, 1, 0, 1, 0, 0, 0, B,  B);
        tbl[6]  = mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0, 0, MP, MP);
        tbl[7]  = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, I,  I);
        tbl[8]  = mk(5'd0, 5'd0, 5'd0, 1, 1, 0, 1, 0, 0, 0, I,  I);
        tbl[9]  = mk(5'd3, 5'd3, 5'd0, 1, 0, 0, 1, 0, 0, 0, I,  I);
        tbl[10] = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, IW, IW);
        tbl[11] = mk(5'd8, 5'd0, 5'd8, 1, 1, 1, 1, 0, 0, 0, MP, MP);
        tbl[12] = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, I,  I);
        tbl[13] = mk(5'd8, 5'd8, 5'd0, 1, 1, 0, 0, 0, 0, 0, B,  B);
        tbl[14] = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0, 0, DW, DW);
        tbl[15] = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0, 0, DW, DW);
        tbl[16] = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0, 0, DW, DW);
        tbl[17] = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0, 0, DW, DW);
        tbl[18] = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 1, 0, I,  B);
        tbl[19] = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, I,  B);
        tbl[20] = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, I,  I);
        tbl[21] = mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 1, 0, 0, DW, DW);
        tbl[22] = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 1, H0, H0);
        tbl[23] = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, H1, H1);
        tbl[24] = mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0, 0, H1, H1);
        tbl[25] = mk(5'd8, 5'd8, 5'd0, 1, 1, 0, 1, 0, 0, 0, H1, H1);

        // Reset: 3 cycles low with idle inputs
        nRST = 1'b0;
        apply(tbl[0]);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        compare("reset");
        chk_perf_zero("reset_perf");
        nRST = 1'b1;

        // Table-driven run
        for (int i = 0; i < NV; i++) begin
            @(posedge CLK);
            #1;
            apply(tbl[i]);
            @(negedge CLK);
`ifdef PIPELINE_CTRL_PERF_EN
            chk($sformatf("vec%0d_ps1", i), ps1, 32'(m_ps1));
            chk($sformatf("vec%0d_pf1", i), pf1, 32'(m_pf1));
            chk($sformatf("vec%0d_ps3", i), 32'(ps3), 32'(m_ps3));
            chk($sformatf("vec%0d_pf3", i), 32'(pf3), 32'(m_pf3));
            perf_step(tbl[i]);
`endif
            compare($sformatf("vec%0d", i));
        end
`ifndef PIPELINE_CTRL_PERF_EN
        chk_perf_zero("perf_tied");
`endif

        // Asynchronous reset mid-cycle leaves HALTED without a clock edge
        @(posedge CLK);
        #1;
        apply(tbl[0]);
        nRST = 1'b0;
        #2;
        compare("async_reset");
        chk_perf_zero("async_reset_perf");
        @(negedge CLK);
        nRST = 1'b1;

        // Halt outranks a pending data wait, then sticks
        @(posedge CLK);
        #1;
        apply(mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0, 1, H0, H0));
        @(negedge CLK);
        compare("halt_over_dwait");
        @(posedge CLK);
        #1;
        apply(mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, H1, H1));
        @(negedge CLK);
        compare("halt_sticky");

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
